// File: rtl/synth_bus_pkg.sv
// Shared types and helpers for the synth parameter bus arbiter/bridge.
package synth_bus_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
  typedef enum logic       {OWN_CPU, OWN_DEC} owner_e;
  typedef enum logic [1:0] {ACC_EXT, ACC_INT, ACC_NONE} acc_e;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bus_fair_arbiter.sv
// Two-requester grant: the decoder has priority, but the CPU wins once it has
// watched FAIR_MAX consecutive decoder grants go by.
module bus_fair_arbiter
  import synth_bus_pkg::*;
#(
  parameter int FAIR_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic cpu_req,
  input  logic dec_req,
  output logic gnt_cpu,
  output logic gnt_dec
);

  localparam int CNT_W = clogb2(FAIR_MAX + 1);

  logic [CNT_W-1:0] fair_q;
  logic             starved;

  assign starved = (fair_q == CNT_W'(FAIR_MAX));
  assign gnt_cpu = arb_en & cpu_req & (~dec_req | starved);
  assign gnt_dec = arb_en & dec_req & ~gnt_cpu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_q <= '0;
    end else if (!cpu_req || gnt_cpu) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      fair_q <= '0;
    end else if (gnt_dec) begin
      fair_q <= fair_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/synth_param_bus_arbiter.sv
// Bridges CPU (Avalon-MM) and MIDI-decoder accesses onto the one-hot synth parameter
// bus, one at a time, and owns the per-part MIDI channel registers.
module synth_param_bus_arbiter
  import synth_bus_pkg::*;
#(
  parameter int NUM_SEL     = 6,
  parameter int SEL_W       = clogb2(NUM_SEL),
  parameter int PADR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int CPU_DATA_W  = 32,
  parameter int COM_SEL_IDX = 4,
  parameter int NUM_PARTS   = 4,
  parameter int WR_STRETCH  = 3,
  parameter int RD_LAT      = 2,
  parameter int FAIR_MAX    = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    cpu_chipselect,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [SEL_W+PADR_W-1:0] cpu_address,
  input  logic [CPU_DATA_W-1:0]   cpu_writedata,
  output logic [CPU_DATA_W-1:0]   cpu_readdata,
  output logic                    cpu_waitrequest,
  input  logic                    dec_req,
  input  logic                    dec_write,
  input  logic [SEL_W-1:0]        dec_sel,
  input  logic [PADR_W-1:0]       dec_adr,
  input  logic [DATA_W-1:0]       dec_data,
  output logic                    dec_ack,
  output logic [DATA_W-1:0]       dec_rdata,
  output logic [NUM_SEL-1:0]      bus_sel,
  output logic [PADR_W-1:0]       bus_adr,
  output logic [DATA_W-1:0]       bus_wdata,
  output logic                    bus_write,
  output logic                    bus_read,
  input  logic [DATA_W-1:0]       bus_rdata,
  output logic [NUM_PARTS*8-1:0]  midi_ch,
  output logic                    busy
);

  localparam int PART_W = clogb2(NUM_PARTS);
  localparam int TMR_W  = clogb2(((WR_STRETCH > RD_LAT) ? WR_STRETCH : RD_LAT) + 1);

  state_e                    state_q;
  owner_e                    owner_q;
  logic [TMR_W-1:0]          tmr_q;
  logic [NUM_PARTS-1:0][7:0] midi_q;
  logic [NUM_SEL-1:0]        bus_sel_q;
  logic [PADR_W-1:0]         bus_adr_q;
  logic [DATA_W-1:0]         bus_wdata_q, dec_rdata_q;
  logic                      bus_write_q, bus_read_q, dec_ack_q, cpu_wait_q;
  logic [CPU_DATA_W-1:0]     cpu_rdata_q;

  logic              cpu_req, gnt_cpu, gnt_dec, grant;
  logic              req_write;
  logic [SEL_W-1:0]  req_sel;
  logic [PADR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_data;
  acc_e              req_acc;
  logic              fin_d;
  owner_e            fin_own_d;
  logic [DATA_W-1:0] fin_data_d;
  logic              unused_wdata_hi;

  assign cpu_req         = cpu_chipselect & (cpu_read | cpu_write);
  assign grant           = gnt_cpu | gnt_dec;
  assign unused_wdata_hi = ^cpu_writedata[CPU_DATA_W-1:DATA_W];

  bus_fair_arbiter #(.FAIR_MAX(FAIR_MAX)) u_arb (
    .clk     (CLOCK_50),
    .rst     (reset),
    .arb_en  (state_q == IDLE),
    .cpu_req (cpu_req),
    .dec_req (dec_req),
    .gnt_cpu (gnt_cpu),
    .gnt_dec (gnt_dec)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_write = dec_write;
    req_sel   = dec_sel;
    req_adr   = dec_adr;
    req_data  = dec_data;
    if (gnt_cpu) begin
      req_write = ~cpu_read;
      req_sel   = cpu_address[PADR_W +: SEL_W];
      req_adr   = cpu_address[PADR_W-1:0];
      req_data  = cpu_writedata[DATA_W-1:0];
    end
    if (int'(req_sel) >= NUM_SEL)
      req_acc = ACC_NONE;
    else if (int'(req_sel) == COM_SEL_IDX && int'(req_adr) < NUM_PARTS)
      req_acc = ACC_INT;
    else
      req_acc = ACC_EXT;
  end

  // Completion is decided one edge early so DONE outputs come straight from flops.
  always_comb begin
    fin_d      = 1'b0;
    fin_own_d  = owner_q;
    fin_data_d = '0;
    unique case (state_q)
      IDLE: if (grant && req_acc != ACC_EXT) begin
        fin_d     = 1'b1;
        fin_own_d = gnt_cpu ? OWN_CPU : OWN_DEC;
        if (req_acc == ACC_INT && !req_write)
          fin_data_d = DATA_W'(midi_q[req_adr[PART_W-1:0]]);
      end
      WRITE: fin_d = (tmr_q == '0);
      READ: begin
        fin_d      = (tmr_q == '0);
        fin_data_d = bus_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      tmr_q       <= '0;
      // NOTE: the channel array is tiny and must read 0x00 after reset, so it is flops with a reset, not RAM.
      midi_q      <= '0;
      bus_sel_q   <= '0;
      bus_adr_q   <= '0;
      bus_wdata_q <= '0;
      bus_write_q <= 1'b0;
      bus_read_q  <= 1'b0;
      dec_ack_q   <= 1'b0;
      dec_rdata_q <= '0;
      cpu_wait_q  <= 1'b1;
      cpu_rdata_q <= '0;
    end else begin
      dec_ack_q  <= 1'b0;
      cpu_wait_q <= 1'b1;
      unique case (state_q)
        IDLE: if (grant) begin
          owner_q <= gnt_cpu ? OWN_CPU : OWN_DEC;
          unique case (req_acc)
            ACC_EXT: begin
              bus_sel_q   <= NUM_SEL'(1) << req_sel;
              bus_adr_q   <= req_adr;
              bus_wdata_q <= req_data;
              bus_write_q <= req_write;
              bus_read_q  <= ~req_write;
              tmr_q       <= req_write ? TMR_W'(WR_STRETCH - 1) : TMR_W'(RD_LAT - 1);
              state_q     <= req_write ? WRITE : READ;
            end
            ACC_INT: begin
              if (req_write) midi_q[req_adr[PART_W-1:0]] <= 8'(req_data);
              state_q <= DONE;
            end
            default: state_q <= DONE;
          endcase
        end
        WRITE, READ: begin
          if (tmr_q == '0) begin
            bus_sel_q   <= '0;
            bus_write_q <= 1'b0;
            bus_read_q  <= 1'b0;
            state_q     <= DONE;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (fin_d) begin
        if (fin_own_d == OWN_CPU) begin
          cpu_wait_q  <= 1'b0;
          cpu_rdata_q <= CPU_DATA_W'(fin_data_d);
        end else begin
          dec_ack_q   <= 1'b1;
          dec_rdata_q <= fin_data_d;
        end
      end
    end
  end

  assign cpu_readdata    = cpu_rdata_q;
  assign cpu_waitrequest = cpu_wait_q;
  assign dec_ack         = dec_ack_q;
  assign dec_rdata       = dec_rdata_q;
  assign bus_sel         = bus_sel_q;
  assign bus_adr         = bus_adr_q;
  assign bus_wdata       = bus_wdata_q;
  assign bus_write       = bus_write_q;
  assign bus_read        = bus_read_q;
  assign midi_ch         = midi_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_synth_param_bus_arbiter.sv
// Scoreboard bench for synth_param_bus_arbiter: drivers push expected completions,
// a negedge monitor pops and compares them as the DUT finishes each access.
module tb_synth_param_bus_arbiter;

  localparam int RD_LAT = 2;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_chipselect, cpu_read, cpu_write;
  logic [9:0]  cpu_address;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic        cpu_waitrequest;
  logic        dec_req, dec_write, dec_ack;
  logic [2:0]  dec_sel;
  logic [6:0]  dec_adr, bus_adr;
  logic [7:0]  dec_data, dec_rdata, bus_wdata, bus_rdata;
  logic [5:0]  bus_sel;
  logic        bus_write, bus_read, busy;
  logic [31:0] midi_ch;

  always #5 CLOCK_50 = ~CLOCK_50;

  synth_param_bus_arbiter dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .cpu_chipselect(cpu_chipselect), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .dec_req(dec_req), .dec_write(dec_write), .dec_sel(dec_sel), .dec_adr(dec_adr),
    .dec_data(dec_data), .dec_ack(dec_ack), .dec_rdata(dec_rdata),
    .bus_sel(bus_sel), .bus_adr(bus_adr), .bus_wdata(bus_wdata),
    .bus_write(bus_write), .bus_read(bus_read), .bus_rdata(bus_rdata),
    .midi_ch(midi_ch), .busy(busy)
  );

  typedef struct { bit chk; logic [31:0] data; } sb_t;
  sb_t        cpu_q[$];
  sb_t        dec_q[$];
  logic [1:0] order_q[$];   // 2'b01 = CPU completion, 2'b10 = decoder completion

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // External block model: read data is valid only on the last cycle of bus_read.
  logic [7:0] rd_value = 8'h00;
  int         rd_run = 0;
  always @(posedge CLOCK_50) rd_run <= bus_read ? rd_run + 1 : 0;
  assign bus_rdata = (bus_read && rd_run == RD_LAT - 1) ? rd_value : 8'hEE;

  int         wr_cyc = 0, rd_cyc = 0, dec_done_cnt = 0;
  logic [5:0] wsel_seen = '0, rsel_seen = '0;
  logic [7:0] wdata_seen = '0;
  logic [6:0] adr_seen = '0;
  always @(negedge CLOCK_50) begin
    if (bus_write) begin
      wr_cyc     <= wr_cyc + 1;
      wsel_seen  <= bus_sel;
      wdata_seen <= bus_wdata;
      adr_seen   <= bus_adr;
    end
    if (bus_read) begin
      rd_cyc    <= rd_cyc + 1;
      rsel_seen <= bus_sel;
      adr_seen  <= bus_adr;
    end
  end

  always @(negedge CLOCK_50) begin : monitor
    sb_t e;
    if (!cpu_waitrequest || dec_ack) begin
      check("done_sel_zero", bus_sel, 0);
      if (order_q.size() != 0) check("grant_order", {dec_ack, !cpu_waitrequest}, order_q.pop_front());
    end
    if (!cpu_waitrequest) begin
      check("cpu_expected", cpu_q.size() != 0, 1);
      if (cpu_q.size() != 0) begin
        e = cpu_q.pop_front();
        if (e.chk) check("cpu_readdata", cpu_readdata, e.data);
      end
    end
    if (dec_ack) begin
      dec_done_cnt <= dec_done_cnt + 1;
      check("dec_expected", dec_q.size() != 0, 1);
      if (dec_q.size() != 0) begin
        e = dec_q.pop_front();
        if (e.chk) check("dec_rdata", dec_rdata, e.data);
      end
    end
  end

  // lat = cycles from the grant edge to the completion cycle (DUT idle when called).
  task automatic cpu_access(input bit rd, input int sel, input int adr, input logic [31:0] wd,
                            input logic [7:0] exp_rd, output int lat);
    sb_t e;
    e.chk = rd;
    e.data = {24'h0, exp_rd};
    cpu_q.push_back(e);
    cpu_chipselect = 1'b1;
    cpu_read = rd;
    cpu_write = !rd;
    cpu_address = {3'(sel), 7'(adr)};
    cpu_writedata = wd;
    lat = 0;
    do begin
      @(negedge CLOCK_50);
      lat++;
    end while (cpu_waitrequest && lat < 40);
    check("cpu_timeout", cpu_waitrequest, 0);
    lat = lat - 1;
    @(posedge CLOCK_50);
    #1;
    cpu_chipselect = 1'b0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic dec_access(input bit wr, input int sel, input int adr, input logic [7:0] wd,
                            input logic [7:0] exp_rd, output int lat);
    sb_t e;
    e.chk = !wr;
    e.data = {24'h0, exp_rd};
    dec_q.push_back(e);
    dec_req = 1'b1;
    dec_write = wr;
    dec_sel = 3'(sel);
    dec_adr = 7'(adr);
    dec_data = wd;
    lat = 0;
    do begin
      @(negedge CLOCK_50);
      lat++;
    end while (!dec_ack && lat < 40);
    check("dec_timeout", dec_ack, 1);
    lat = lat - 1;
    @(posedge CLOCK_50);
    #1;
    dec_req = 1'b0;
  endtask

  initial begin
    int lat, lat_c, lat_d, w0, r0, d0;
    cpu_chipselect = 0; cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_writedata = '0;
    dec_req = 0; dec_write = 0; dec_sel = '0; dec_adr = '0; dec_data = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_waitrequest", cpu_waitrequest, 1);
    check("rst_dec_ack", dec_ack, 0);
    check("rst_strobes", {bus_write, bus_read}, 0);
    check("rst_bus_sel", bus_sel, 0);
    check("rst_midi_ch", midi_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_readdata", cpu_readdata, 0);
    @(posedge CLOCK_50); #1 reset = 1'b0;
    @(posedge CLOCK_50); #1;

    // External CPU write.
    w0 = wr_cyc; r0 = rd_cyc;
    cpu_access(0, 1, 'h12, 32'h0000_00A5, 8'h00, lat);
    check("ext_wr_latency", lat, 4);
    check("ext_wr_cycles", wr_cyc - w0, 3);
    check("ext_wr_sel", wsel_seen, 6'b000010);
    check("ext_wr_data", wdata_seen, 8'hA5);
    check("ext_wr_adr", adr_seen, 7'h12);
    check("ext_wr_no_read", rd_cyc - r0, 0);

    // External decoder read.
    rd_value = 8'h5C; w0 = wr_cyc; r0 = rd_cyc;
    dec_access(0, 0, 3, 8'h00, 8'h5C, lat);
    check("ext_rd_latency", lat, 3);
    check("ext_rd_cycles", rd_cyc - r0, 2);
    check("ext_rd_sel", rsel_seen, 6'b000001);
    check("ext_rd_adr", adr_seen, 7'h03);
    check("ext_rd_no_write", wr_cyc - w0, 0);

    // Internal channel registers; upper CPU data bits must be ignored.
    w0 = wr_cyc; r0 = rd_cyc;
    cpu_access(0, 4, 2, 32'hFFFF_FF09, 8'h00, lat);
    check("int_wr_latency", lat, 1);
    check("int_wr_midi2", midi_ch[23:16], 8'h09);
    cpu_access(1, 4, 2, 32'h0, 8'h09, lat);
    check("int_rd_latency", lat, 1);
    dec_access(1, 4, 0, 8'h03, 8'h00, lat);
    dec_access(0, 4, 0, 8'h00, 8'h03, lat);
    check("int_midi_all", midi_ch, 32'h0009_0003);
    check("int_no_strobes", (wr_cyc - w0) + (rd_cyc - r0), 0);

    // CPU external read, then invalid select.
    rd_value = 8'hC3;
    cpu_access(1, 2, 'h7F, 32'h0, 8'hC3, lat);
    check("cpu_ext_rd_latency", lat, 3);
    w0 = wr_cyc; r0 = rd_cyc;
    cpu_access(1, 7, 'h12, 32'h0, 8'h00, lat);
    check("inv_rd_latency", lat, 1);
    cpu_access(0, 7, 'h01, 32'h0000_0055, 8'h00, lat);
    check("inv_no_strobes", (wr_cyc - w0) + (rd_cyc - r0), 0);

    // Common block, address beyond the parts: goes out on the bus.
    w0 = wr_cyc;
    cpu_access(0, 4, 4, 32'h0000_005A, 8'h00, lat);
    check("com_ext_cycles", wr_cyc - w0, 3);
    check("com_ext_sel", wsel_seen, 6'b010000);
    check("com_ext_adr", adr_seen, 7'h04);
    check("com_ext_midi", midi_ch, 32'h0009_0003);

    // Both request continuously: four decoder grants, then one CPU grant.
    for (int k = 0; k < 2; k++) begin
      repeat (4) order_q.push_back(2'b10);
      order_q.push_back(2'b01);
    end
    fork
      begin
        for (int i = 0; i < 2; i++) cpu_access(0, 4, i, 32'(i + 1), 8'h00, lat_c);
      end
      begin
        for (int i = 0; i < 8; i++) dec_access(1, 4, i % 4, 8'(i + 16), 8'h00, lat_d);
      end
    join
    check("fair_midi", midi_ch, 32'h1716_0214);

    // Reset in the second cycle of an external decoder write.
    d0 = dec_done_cnt;
    dec_req = 1'b1; dec_write = 1'b1; dec_sel = 3'd1; dec_adr = 7'd5; dec_data = 8'h77;
    lat = 0;
    do begin
      @(negedge CLOCK_50);
      lat++;
    end while (!bus_write && lat < 20);
    check("abort_wr_start", bus_write, 1);
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    check("abort_wr_drop", bus_write, 0);
    check("abort_busy", busy, 0);
    check("abort_sel", bus_sel, 0);
    check("abort_midi", midi_ch, 0);
    dec_req = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (8) @(posedge CLOCK_50);
    #1;
    check("abort_no_ack", dec_done_cnt - d0, 0);

    check("cpu_sb_drain", cpu_q.size(), 0);
    check("dec_sb_drain", dec_q.size(), 0);
    check("order_drain", order_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
